// File: rtl/alu_operand_collector_pkg.sv
// alu_coll_pkg: shared types and helpers for the ALU operand collector.
//   coll_state_e        : collector FSM states.
//   needs_two()         : whether a (mode, cmd) pair consumes both operands.
//   DEFAULT_WAIT_CYCLES : default bound on the wait for a missing operand.
// Also provides fallback values for the shared `DATA_WIDTH / `CMD_WIDTH defines.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CMD_WIDTH
`define CMD_WIDTH 4
`endif

package alu_coll_pkg;

  localparam int DEFAULT_WAIT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SECOND,
    ISSUE
  } coll_state_e;

  // Single-operand commands form one contiguous range per mode; everything
  // else, including unknown encodings, waits for both operands.
  function automatic logic needs_two(input logic mode, input int unsigned cmd);
    logic two;
    two = 1'b1;
    if (mode) begin
      if (cmd >= 4 && cmd <= 7) two = 1'b0;
    end else begin
      if (cmd >= 6 && cmd <= 11) two = 1'b0;
    end
    return two;
  endfunction

endpackage

// File: rtl/alu_operand_collector_if.sv
// alu_operand_collector_if: upstream beat channel into the operand collector.
//   in_valid/in_ready : valid/ready handshake, beat accepted when both high.
//   in_opa/in_opb     : operand payloads.
//   in_inp_valid      : bit0 = OPA present, bit1 = OPB present.
//   in_cmd/in_mode/in_cin : command, 1 = arithmetic / 0 = logical, carry in.
// Modports: master = beat producer, slave = collector.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CMD_WIDTH
`define CMD_WIDTH 4
`endif

interface alu_operand_collector_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CMD_WIDTH  = `CMD_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_opa;
  logic [DATA_WIDTH-1:0] in_opb;
  logic [1:0]            in_inp_valid;
  logic [CMD_WIDTH-1:0]  in_cmd;
  logic                  in_mode;
  logic                  in_cin;

  modport master (
    output in_valid, in_opa, in_opb, in_inp_valid, in_cmd, in_mode, in_cin,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opa, in_opb, in_inp_valid, in_cmd, in_mode, in_cin,
    output in_ready
  );
endinterface

// File: rtl/alu_operand_collector_timer.sv
// alu_coll_timer: bounded wait counter for the operand collector.
//   clk, reset : clock, asynchronous active-high reset.
//   clear      : force the count to zero (wins over enable).
//   enable     : advance the count by one per cycle.
//   expired    : count has reached WAIT_CYCLES-1.
module alu_coll_timer
  import alu_coll_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Counter parks at LAST so a stalled enable can never wrap it around.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);
endmodule

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: pairs split operand beats and issues complete ALU ops.
//   clk, reset    : clock, asynchronous active-high reset.
//   beat          : upstream beat channel (alu_operand_collector_if.slave).
//   OPA, OPB      : issued operands.
//   CIN, MODE     : issued carry in and mode.
//   CMD           : issued command.
//   INP_VALID     : issued operand-present flags (11 = complete pair).
//   CE            : one-cycle issue strobe.
//   timeout_err   : one-cycle pulse for a dropped beat or a partial issue.
// Optional macro ALU_COLL_STATS_EN adds saturating counters issue_cnt and
// timeout_cnt [15:0].
module alu_operand_collector
  import alu_coll_pkg::*;
#(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int CMD_WIDTH   = `CMD_WIDTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_operand_collector_if.slave beat,
  output logic [DATA_WIDTH-1:0]  OPA,
  output logic [DATA_WIDTH-1:0]  OPB,
  output logic                   CIN,
  output logic                   MODE,
  output logic [CMD_WIDTH-1:0]   CMD,
  output logic [1:0]             INP_VALID,
  output logic                   CE,
  output logic                   timeout_err
`ifdef ALU_COLL_STATS_EN
  ,
  output logic [15:0]            issue_cnt,
  output logic [15:0]            timeout_cnt
`endif
);

  coll_state_e state, next_state;

  logic                  ready_q;
  logic                  accept;
  logic                  expired;
  logic                  timer_clear;
  logic                  drop_err;

  logic [DATA_WIDTH-1:0] hold_opa, nxt_opa;
  logic [DATA_WIDTH-1:0] hold_opb, nxt_opb;
  logic [1:0]            hold_flags, nxt_flags;
  logic [CMD_WIDTH-1:0]  hold_cmd, nxt_cmd;
  logic                  hold_mode, nxt_mode;
  logic                  hold_cin, nxt_cin;
  logic                  hold_err, nxt_err;
  logic [1:0]            missing;

  // ready is registered so it stays low through reset and rises on the
  // first edge after release.
  assign beat.in_ready = ready_q;
  assign accept        = beat.in_valid && ready_q;
  assign missing       = ~hold_flags;

  alu_coll_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (state == WAIT_SECOND),
    .expired (expired)
  );

  // Next-state and holding-register update. Absent operands are latched as
  // zero so a partial issue never leaks a stale value.
  always_comb begin
    next_state  = state;
    nxt_opa     = hold_opa;
    nxt_opb     = hold_opb;
    nxt_flags   = hold_flags;
    nxt_cmd     = hold_cmd;
    nxt_mode    = hold_mode;
    nxt_cin     = hold_cin;
    nxt_err     = hold_err;
    timer_clear = 1'b0;
    drop_err    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (beat.in_inp_valid == 2'b00) begin
            drop_err = 1'b1;
          end else begin
            nxt_opa   = beat.in_inp_valid[0] ? beat.in_opa : '0;
            nxt_opb   = beat.in_inp_valid[1] ? beat.in_opb : '0;
            nxt_flags = beat.in_inp_valid;
            nxt_cmd   = beat.in_cmd;
            nxt_mode  = beat.in_mode;
            nxt_cin   = beat.in_cin;
            nxt_err   = 1'b0;
            if (needs_two(beat.in_mode, 32'(beat.in_cmd)) && beat.in_inp_valid != 2'b11) begin
              next_state  = WAIT_SECOND;
              timer_clear = 1'b1;
            end else begin
              next_state = ISSUE;
            end
          end
        end
      end
      WAIT_SECOND: begin
        // A completing beat takes priority over an expiry in the same cycle.
        if (accept && |(beat.in_inp_valid & missing)) begin
          if (missing[0]) nxt_opa = beat.in_opa;
          if (missing[1]) nxt_opb = beat.in_opb;
          nxt_flags  = 2'b11;
          next_state = ISSUE;
        end else if (expired) begin
          nxt_err    = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        nxt_err    = 1'b0;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, holding registers and the ALU-facing output registers. Outputs
  // load only while in ISSUE, so they hold the last issued op otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      hold_opa    <= '0;
      hold_opb    <= '0;
      hold_flags  <= '0;
      hold_cmd    <= '0;
      hold_mode   <= 1'b0;
      hold_cin    <= 1'b0;
      hold_err    <= 1'b0;
      OPA         <= '0;
      OPB         <= '0;
      CIN         <= 1'b0;
      MODE        <= 1'b0;
      CMD         <= '0;
      INP_VALID   <= '0;
      CE          <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= next_state;
      ready_q     <= (next_state != ISSUE);
      hold_opa    <= nxt_opa;
      hold_opb    <= nxt_opb;
      hold_flags  <= nxt_flags;
      hold_cmd    <= nxt_cmd;
      hold_mode   <= nxt_mode;
      hold_cin    <= nxt_cin;
      hold_err    <= nxt_err;
      CE          <= (state == ISSUE);
      timeout_err <= drop_err || (state == ISSUE && hold_err);
      if (state == ISSUE) begin
        OPA       <= hold_opa;
        OPB       <= hold_opb;
        CIN       <= hold_cin;
        MODE      <= hold_mode;
        CMD       <= hold_cmd;
        INP_VALID <= hold_flags;
      end
    end
  end

`ifdef ALU_COLL_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      if (CE && issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;
      if (timeout_err && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
    end
  end
`endif

endmodule
